// File: rtl/bc_msg_timer_ctrl.sv
// MIL-1553 bus-controller message sequencer: intermessage gap, encoder start, response timeout, retry.
// Define MSG_TIMER_RETRY_EN to enable retransmission after a response timeout.
module bc_msg_timer_ctrl #(
    parameter int GAP_CYCLES          = 200,
    parameter int RESP_TIMEOUT_CYCLES = 700,
    parameter int MAX_RETRIES         = 1,
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_msg_valid,
    output logic          o_msg_ready,
    input  logic          i_expect_resp,
    input  logic          i_tx_done,
    input  logic          i_rx_sync,
    input  logic          i_rx_done,
    input  logic          i_abort,
    output logic          o_tx_go,
    output logic          o_busy,
    output logic          o_msg_done,
    output logic          o_timeout,
    output logic [RW-1:0] o_retry_count
);

    localparam int GW = $clog2(GAP_CYCLES + 1);
    localparam int TW = $clog2(RESP_TIMEOUT_CYCLES + 1);
    // Counters are loaded with N-1 so the state lasts exactly N cycles, ending when they hit 0.
    localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(RESP_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        TX,
        WAIT_RESP,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          expect_q, expect_d;
    logic          tx_go_d, msg_done_d, timeout_d;
    logic          retry_ok;

`ifdef MSG_TIMER_RETRY_EN
    logic [RW-1:0] retry_q, retry_d;
    assign retry_ok      = (retry_q < RW'(MAX_RETRIES));
    assign o_retry_count = retry_q;
`else
    assign retry_ok      = 1'b0;
    assign o_retry_count = '0;
`endif

    assign o_msg_ready = (state_q == IDLE);
    assign o_busy      = (state_q != IDLE);

    // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        gap_d      = gap_q;
        tmo_d      = tmo_q;
        expect_d   = expect_q;
        tx_go_d    = 1'b0;
        msg_done_d = 1'b0;
        timeout_d  = 1'b0;
`ifdef MSG_TIMER_RETRY_EN
        retry_d    = retry_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_msg_valid) begin
                    state_d  = GAP;
                    expect_d = i_expect_resp;
                    gap_d    = GAP_LOAD;
`ifdef MSG_TIMER_RETRY_EN
                    retry_d  = '0;
`endif
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    state_d = TX;
                    tx_go_d = 1'b1;
                end else begin
                    gap_d = gap_q - 1'b1;
                end
            end
            TX: begin
                if (i_tx_done) begin
                    if (expect_q) begin
                        state_d = WAIT_RESP;
                        tmo_d   = TMO_LOAD;
                    end else begin
                        state_d    = IDLE;
                        msg_done_d = 1'b1;
                    end
                end
            end
            WAIT_RESP: begin
                // A sync on the last window cycle wins over the expiry.
                if (i_rx_sync) begin
                    state_d = RESP;
                    tmo_d   = '0;
                end else if (tmo_q == '0) begin
                    if (retry_ok) begin
                        state_d = GAP;
                        gap_d   = GAP_LOAD;
`ifdef MSG_TIMER_RETRY_EN
                        retry_d = retry_q + 1'b1;
`endif
                    end else begin
                        state_d   = IDLE;
                        timeout_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q - 1'b1;
                end
            end
            RESP: begin
                if (i_rx_done) begin
                    state_d    = IDLE;
                    msg_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_abort && (state_q != IDLE)) begin
            state_d    = IDLE;
            gap_d      = '0;
            tmo_d      = '0;
            tx_go_d    = 1'b0;
            msg_done_d = 1'b0;
            timeout_d  = 1'b0;
`ifdef MSG_TIMER_RETRY_EN
            retry_d    = retry_q;
`endif
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            gap_q      <= '0;
            tmo_q      <= '0;
            expect_q   <= 1'b0;
            o_tx_go    <= 1'b0;
            o_msg_done <= 1'b0;
            o_timeout  <= 1'b0;
`ifdef MSG_TIMER_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            gap_q      <= gap_d;
            tmo_q      <= tmo_d;
            expect_q   <= expect_d;
            o_tx_go    <= tx_go_d;
            o_msg_done <= msg_done_d;
            o_timeout  <= timeout_d;
`ifdef MSG_TIMER_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

endmodule

// File: tb/tb_bc_msg_timer_ctrl.sv
// Self-checking bench for bc_msg_timer_ctrl: deadline-based reference model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_bc_msg_timer_ctrl;

    localparam int GAP  = 4;
    localparam int RESP = 8;
    localparam int MAXR = 1;
`ifdef MSG_TIMER_RETRY_EN
    localparam int EFF_RETRIES = MAXR;
`else
    localparam int EFF_RETRIES = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic msg_valid = 1'b0, expect_resp = 1'b0, tx_done = 1'b0;
    logic rx_sync = 1'b0, rx_done = 1'b0, abort = 1'b0;
    logic msg_ready, tx_go, busy, msg_done, timeout;
    logic [0:0] retry_count;

    bc_msg_timer_ctrl #(
        .GAP_CYCLES(GAP),
        .RESP_TIMEOUT_CYCLES(RESP),
        .MAX_RETRIES(MAXR)
    ) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_msg_valid(msg_valid),
        .o_msg_ready(msg_ready),
        .i_expect_resp(expect_resp),
        .i_tx_done(tx_done),
        .i_rx_sync(rx_sync),
        .i_rx_done(rx_done),
        .i_abort(abort),
        .o_tx_go(tx_go),
        .o_busy(busy),
        .o_msg_done(msg_done),
        .o_timeout(timeout),
        .o_retry_count(retry_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: phases with absolute-cycle deadlines for the gap end and response window end.
    typedef enum {M_IDLE, M_GAP, M_TX, M_WAIT, M_RESP} mphase_t;
    mphase_t m_phase = M_IDLE;
    bit m_exp = 1'b0;
    int m_rc = 0;
    int m_go_at = 0;
    int m_win_end = 0;
    bit e_go = 1'b0, e_done = 1'b0, e_to = 1'b0;

    initial forever begin
        @(posedge clk);
        e_go = 1'b0; e_done = 1'b0; e_to = 1'b0;
        if (!rst_n) begin
            m_phase = M_IDLE;
            m_rc = 0;
        end else if (abort && m_phase != M_IDLE) begin
            m_phase = M_IDLE;
        end else begin
            case (m_phase)
                M_IDLE: if (msg_valid) begin
                    m_phase = M_GAP; m_exp = expect_resp; m_rc = 0; m_go_at = cyc + 1 + GAP;
                end
                M_GAP: if (cyc + 1 == m_go_at) begin
                    m_phase = M_TX; e_go = 1'b1;
                end
                M_TX: if (tx_done) begin
                    if (m_exp) begin
                        m_phase = M_WAIT; m_win_end = cyc + RESP;
                    end else begin
                        m_phase = M_IDLE; e_done = 1'b1;
                    end
                end
                M_WAIT: if (rx_sync) begin
                    m_phase = M_RESP;
                end else if (cyc == m_win_end) begin
                    if (m_rc < EFF_RETRIES) begin
                        m_rc++; m_phase = M_GAP; m_go_at = cyc + 1 + GAP;
                    end else begin
                        m_phase = M_IDLE; e_to = 1'b1;
                    end
                end
                M_RESP: if (rx_done) begin
                    m_phase = M_IDLE; e_done = 1'b1;
                end
                default: m_phase = M_IDLE;
            endcase
        end
        cyc++;
    end

    // Per-cycle compare plus a pulse log used by the directed scenarios.
    int go_cnt = 0, done_cnt = 0, to_cnt = 0;
    int last_go = -1, last_done = -1, last_to = -1, last_rdy = -1;
    bit prev_ready = 1'b1;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            check("rst_ready", int'(msg_ready), 1);
            check("rst_busy", int'(busy), 0);
            check("rst_tx_go", int'(tx_go), 0);
            check("rst_msg_done", int'(msg_done), 0);
            check("rst_timeout", int'(timeout), 0);
            check("rst_retry_count", int'(retry_count), 0);
        end else begin
            check("msg_ready", int'(msg_ready), int'(m_phase == M_IDLE));
            check("busy", int'(busy), int'(m_phase != M_IDLE));
            check("tx_go", int'(tx_go), int'(e_go));
            check("msg_done", int'(msg_done), int'(e_done));
            check("timeout", int'(timeout), int'(e_to));
            check("retry_count", int'(retry_count), m_rc);
        end
        if (tx_go === 1'b1) begin go_cnt++; last_go = cyc; end
        if (msg_done === 1'b1) begin done_cnt++; last_done = cyc; end
        if (timeout === 1'b1) begin to_cnt++; last_to = cyc; end
        if (msg_ready === 1'b1 && !prev_ready) last_rdy = cyc;
        prev_ready = (msg_ready === 1'b1);
    end

    // Offsets are relative to the cycle of the first accept; -1 means never.
    task automatic run_scn(input int len, input int v1, input bit e1, input int v2, input bit e2,
                           input int td1, input int td2, input int sy, input int rd, input int ab,
                           output int base);
        base = cyc;
        for (int i = 0; i < len; i++) begin
            msg_valid   = (i == v1) || (i == v2);
            expect_resp = (i == v2) ? e2 : e1;
            tx_done     = (i == td1) || (i == td2);
            rx_sync     = (i == sy);
            rx_done     = (i == rd);
            abort       = (i == ab);
            @(negedge clk);
        end
        msg_valid = 0; expect_resp = 0; tx_done = 0; rx_sync = 0; rx_done = 0; abort = 0;
        repeat (2) @(negedge clk);
    endtask

    int b, go0, done0, to0;

    initial begin
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_ready", int'(msg_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_retry", int'(retry_count), 0);

        // Broadcast: go at +5, done and ready back at +11.
        go0 = go_cnt; done0 = done_cnt;
        run_scn(16, 0, 1'b0, -1, 1'b0, 10, -1, -1, -1, -1, b);
        check("bc_go_cycle", last_go - b, 5);
        check("bc_done_cycle", last_done - b, 11);
        check("bc_ready_cycle", last_rdy - b, 11);
        check("bc_go_count", go_cnt - go0, 1);

        // Normal response.
        to0 = to_cnt;
        run_scn(36, 0, 1'b1, -1, 1'b0, 10, -1, 15, 30, -1, b);
        check("resp_done_cycle", last_done - b, 31);
        check("resp_no_timeout", to_cnt - to0, 0);

        // Sync on the final window cycle.
        to0 = to_cnt;
        run_scn(26, 0, 1'b1, -1, 1'b0, 10, -1, 18, 20, -1, b);
        check("edge_done_cycle", last_done - b, 21);
        check("edge_no_timeout", to_cnt - to0, 0);
        check("edge_retry_count", int'(retry_count), 0);

        // No response at all.
        go0 = go_cnt; to0 = to_cnt;
        run_scn(40, 0, 1'b1, -1, 1'b0, 10, 25, -1, -1, -1, b);
        check("to_pulse_count", to_cnt - to0, 1);
`ifdef MSG_TIMER_RETRY_EN
        check("retry_go_cycle", last_go - b, 23);
        check("retry_to_cycle", last_to - b, 34);
        check("retry_go_count", go_cnt - go0, 2);
        check("retry_final_count", int'(retry_count), 1);
`else
        check("noretry_to_cycle", last_to - b, 19);
        check("noretry_go_count", go_cnt - go0, 1);
        check("noretry_final_count", int'(retry_count), 0);
`endif

        // Abort in WAIT_RESP, then a new broadcast accepted on the first IDLE cycle.
        go0 = go_cnt; done0 = done_cnt; to0 = to_cnt;
        run_scn(28, 0, 1'b1, 15, 1'b0, 10, 22, -1, -1, 14, b);
        check("abort_go_cycle", last_go - b, 20);
        check("abort_go_count", go_cnt - go0, 2);
        check("abort_done_cycle", last_done - b, 23);
        check("abort_done_count", done_cnt - done0, 1);
        check("abort_no_timeout", to_cnt - to0, 0);

        // Asynchronous reset during GAP.
        msg_valid = 1'b1; expect_resp = 1'b0;
        @(negedge clk);
        msg_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_busy", int'(busy), 0);
        check("async_rst_ready", int'(msg_ready), 1);
        go0 = go_cnt;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("rst_no_go", go_cnt - go0, 0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            msg_valid   = ($urandom_range(99) < 30);
            expect_resp = $urandom_range(1);
            tx_done     = ($urandom_range(99) < 15);
            rx_sync     = ($urandom_range(99) < 8);
            rx_done     = ($urandom_range(99) < 15);
            abort       = ($urandom_range(99) < 2);
            @(negedge clk);
        end
        msg_valid = 0; expect_resp = 0; tx_done = 0; rx_sync = 0; rx_done = 0; abort = 0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/bc_msg_timer_ctrl.md
Name: bc_msg_timer_ctrl

Overview:
- Bus-controller message sequencer for the MIL-1553 transmit/receive path.
- Enforces the intermessage gap before each transmission, then starts the encoder and runs the RT response-timeout window.
- Reports response, timeout or retry outcomes.
- Drives two internal down-counter instances (gap, response timeout) via their clear/enable inputs; sits between the BC message scheduler and the Manchester encoder/decoder.

Parameters:
- GAP_CYCLES, 200, intermessage gap length in clocks (4 us at 50 MHz); must be > 0.
- RESP_TIMEOUT_CYCLES, 700, response-timeout window in clocks (14 us at 50 MHz); must be > 0.
- MAX_RETRIES, 1, retransmissions after a timeout; width of o_retry_count is $clog2(MAX_RETRIES+1), minimum 1.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_msg_valid  in  1  scheduler requests a message.
- o_msg_ready  out  1  high only in IDLE; a message is accepted when i_msg_valid & o_msg_ready.
- i_expect_resp  in  1  sampled at accept; 0 = broadcast, no response expected.
- i_tx_done  in  1  pulse from the encoder: last word sent.
- i_rx_sync  in  1  pulse from the decoder: status-word sync detected.
- i_rx_done  in  1  pulse from the decoder: response fully received.
- i_abort  in  1  synchronous abort.
- o_tx_go  out  1  one-cycle pulse to the encoder.
- o_busy  out  1  state != IDLE.
- o_msg_done  out  1  one-cycle pulse: message completed successfully.
- o_timeout  out  1  one-cycle pulse: retries exhausted with no response.
- o_retry_count  out  RW  retries used in the current message.

Behaviour:
- Reset values: state IDLE, o_msg_ready=1, all pulses 0, o_busy=0, o_retry_count=0, both counters 0.
- States: IDLE, GAP, TX, WAIT_RESP, RESP.
- IDLE -> GAP on accept.
  - Latch i_expect_resp.
  - Clear o_retry_count.
  - Load gap counter.
- GAP:
  - Lasts exactly GAP_CYCLES cycles.
  - Exits to TX on the cycle the counter reaches 0.
- TX:
  - o_tx_go pulses on the first TX cycle only.
  - Waits for i_tx_done.
  - If i_expect_resp was latched 1: go to WAIT_RESP and load the timeout counter.
  - Otherwise: go to IDLE and pulse o_msg_done.
  - Latency from the accept cycle N to o_tx_go is N+1+GAP_CYCLES.
- WAIT_RESP:
  - The window is the RESP_TIMEOUT_CYCLES cycles following the i_tx_done cycle.
  - i_rx_sync inside the window -> RESP.
  - i_rx_sync on the final window cycle counts as in-window; sync beats timeout.
  - On expiry with o_retry_count < MAX_RETRIES: increment o_retry_count and go to GAP (retransmit after a full gap).
  - On expiry with retries exhausted: pulse o_timeout and go to IDLE.
- RESP: i_rx_done -> IDLE, pulse o_msg_done.
- Pulses not listed for a state are ignored in that state (e.g. i_tx_done in GAP, i_rx_sync in TX).
- i_abort in any non-IDLE state:
  - IDLE next cycle.
  - No o_tx_go, o_msg_done or o_timeout pulse.
  - Counters cleared.
  - i_abort overrides all same-cycle events.
  - i_abort in IDLE has no effect.
- o_msg_ready is 0 the cycle after accept. An i_msg_valid held through a busy period is accepted on the first IDLE cycle.
- Reset mid-message: immediate return to IDLE, all outputs at reset values, no pulses.
- Counter width per instance: $clog2(count+1). Counters saturate at 0.

Optional Feature:
- Macro: MSG_TIMER_RETRY_EN.
- Defined: retry behaviour as above.
- Undefined:
  - MAX_RETRIES is ignored.
  - First timeout pulses o_timeout and returns to IDLE.
  - o_retry_count is tied to 0.

Test Plan (GAP_CYCLES=4, RESP_TIMEOUT_CYCLES=8, MAX_RETRIES=1, MSG_TIMER_RETRY_EN defined):
- Broadcast: accept at cycle 10 with i_expect_resp=0 -> o_tx_go at cycle 15; i_tx_done at 20 -> o_msg_done at 21, o_msg_ready=1 at 21.
- Normal response: i_expect_resp=1, i_tx_done at cycle 20, i_rx_sync at 25, i_rx_done at 40 -> o_msg_done at 41, o_timeout never asserted.
- Boundary sync: i_tx_done at 20, i_rx_sync at 28 (last window cycle) -> RESP entered, no timeout, no retry.
- Retry then timeout:
  - No i_rx_sync -> retry at 29, o_retry_count=1.
  - o_tx_go 4 gap cycles later.
  - Second window expires -> o_timeout single pulse, o_retry_count=1, IDLE.
- Abort during WAIT_RESP at cycle 24 -> IDLE at 25; o_msg_done, o_timeout and o_tx_go stay 0; a new accept at 25 produces o_tx_go at 30.
- i_rst_n low during GAP -> o_busy=0 and o_msg_ready=1 asynchronously; no o_tx_go after release.
